// File: rtl/bisr_pkg.sv
// Shared definitions for the result-drain block.
//   drain_state_t : stream FSM states (IDLE, HDR, DRAIN)
//   Q16_FRAC_W    : fraction width of the Q16.16 result words
package bisr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HDR   = 2'd1,
        DRAIN = 2'd2
    } drain_state_t;

    localparam int Q16_FRAC_W = 16;

endpackage

// File: rtl/stw_fault_counter.sv
// Combinational count of faulty cells in a diagnosis map.
// Ports:
//   map       in  CELLS       diagnosis bits, 1 = healthy, 0 = faulty
//   fault_cnt out CNT_W       number of zero bits in map
module stw_fault_counter #(
    parameter int CELLS = 16,
    parameter int CNT_W = $clog2(CELLS + 1)
) (
    input  logic [CELLS-1:0] map,
    output logic [CNT_W-1:0] fault_cnt
);

    always_comb begin
        fault_cnt = '0;
        for (int i = 0; i < CELLS; i++) begin
            fault_cnt = fault_cnt + CNT_W'(!map[i]);
        end
    end

endmodule

// File: rtl/os_result_drain.sv
// Captures a finished array result plus its diagnosis map and streams it out
// over a valid/ready interface: one header word (fault count) followed by the
// ROWS*COLS elements in row-major order.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   output_matrix   flat result, element (r,c) at (r*COLS+c)*WORD_SIZE
//   matrix_rdy      level from the array; a rising edge marks a new result
//   STW_result_mat  diagnosis map, 1 = no fault
//   out_data        streamed word (header count or element)
//   out_valid       stream outputs are valid
//   out_ready       downstream accept
//   out_hdr         current word is the header
//   out_row/out_col index of current element (0 during header)
//   out_last        current word is the final element
//   busy            FSM not idle
//   overrun_err     sticky: a result arrived while a stream was in progress
module os_result_drain
    import bisr_pkg::*;
#(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int WORD_SIZE = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ROWS*COLS*WORD_SIZE-1:0] output_matrix,
    input  logic                           matrix_rdy,
    input  logic [ROWS*COLS-1:0]           STW_result_mat,
    output logic [WORD_SIZE-1:0]           out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_hdr,
    output logic [$clog2(ROWS)-1:0]        out_row,
    output logic [$clog2(COLS)-1:0]        out_col,
    output logic                           out_last,
    output logic                           busy,
    output logic                           overrun_err
);

    localparam int N     = ROWS * COLS;
    localparam int RW    = $clog2(ROWS);
    localparam int CW    = $clog2(COLS);
    localparam int FW    = $clog2(N + 1);

    drain_state_t               state_q, state_d;
    logic                       rdy_q, rdy_d;
    logic                       arm_q, arm_d;
    logic [N*WORD_SIZE-1:0]     mat_q, mat_d;
    logic [N-1:0]               map_q, map_d;
    logic [RW-1:0]              row_q, row_d;
    logic [CW-1:0]              col_q, col_d;
    logic                       ovr_q, ovr_d;

    logic                       capture;
    logic                       xfer;
    logic                       at_last;
    logic [FW-1:0]              fault_cnt;
    int                         elem_idx;

    stw_fault_counter #(
        .CELLS (N),
        .CNT_W (FW)
    ) u_fault_cnt (
        .map       (map_q),
        .fault_cnt (fault_cnt)
    );

    // arm_q is cleared by reset and set on the first clock after it, so a
    // matrix_rdy level already high across reset is never mistaken for a
    // fresh rising edge.
    assign capture = arm_q & matrix_rdy & ~rdy_q;
    assign xfer    = (state_q != IDLE) & out_ready;
    assign at_last = (row_q == RW'(ROWS - 1)) && (col_q == CW'(COLS - 1));

    always_comb begin
        state_d = state_q;
        rdy_d   = matrix_rdy;
        arm_d   = 1'b1;
        mat_d   = mat_q;
        map_d   = map_q;
        row_d   = row_q;
        col_d   = col_q;
        ovr_d   = ovr_q;

        case (state_q)
            IDLE: begin
                if (capture) begin
                    mat_d   = output_matrix;
                    map_d   = STW_result_mat;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = HDR;
                end
            end
            HDR: begin
                if (capture) ovr_d = 1'b1;
                if (xfer) begin
                    row_d   = '0;
                    col_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // A capture on the final-transfer edge is still an overrun.
                if (capture) ovr_d = 1'b1;
                if (xfer) begin
                    if (at_last) begin
                        row_d   = '0;
                        col_d   = '0;
                        state_d = IDLE;
                    end else if (col_q == CW'(COLS - 1)) begin
                        col_d = '0;
                        row_d = row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
            arm_q   <= 1'b0;
            mat_q   <= '0;
            map_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            arm_q   <= arm_d;
            mat_q   <= mat_d;
            map_q   <= map_d;
            row_q   <= row_d;
            col_q   <= col_d;
            ovr_q   <= ovr_d;
        end
    end

    // Outputs are pure decodes of flops, so they hold while ready is low.
    assign elem_idx = int'(row_q) * COLS + int'(col_q);

    always_comb begin
        out_data = '0;
        case (state_q)
            HDR:     out_data = WORD_SIZE'(fault_cnt);
            DRAIN:   out_data = mat_q[elem_idx*WORD_SIZE +: WORD_SIZE];
            default: out_data = '0;
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign out_valid   = busy;
    assign out_hdr     = (state_q == HDR);
    assign out_last    = (state_q == DRAIN) && at_last;
    assign out_row     = row_q;
    assign out_col     = col_q;
    assign overrun_err = ovr_q;

endmodule

// File: tb/tb_os_result_drain.sv
module tb_os_result_drain;

    localparam int R = 2;
    localparam int C = 2;
    localparam int W = 32;
    localparam int N = R * C;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N*W-1:0]   mat;
    logic             rdy;
    logic [N-1:0]     map;
    logic [W-1:0]     out_data;
    logic             out_valid;
    logic             ready;
    logic             out_hdr;
    logic             out_row;
    logic             out_col;
    logic             out_last;
    logic             busy;
    logic             overrun_err;

    os_result_drain #(.ROWS(R), .COLS(C), .WORD_SIZE(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .output_matrix  (mat),
        .matrix_rdy     (rdy),
        .STW_result_mat (map),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (ready),
        .out_hdr        (out_hdr),
        .out_row        (out_row),
        .out_col        (out_col),
        .out_last       (out_last),
        .busy           (busy),
        .overrun_err    (overrun_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of the words still owed downstream.
    typedef struct {
        logic [W-1:0] data;
        logic         hdr;
        int           row;
        int           col;
        logic         last;
    } word_t;

    word_t        expq[$];
    logic         m_ovr = 1'b0;
    logic         prev_rdy = 1'b1;
    logic [W-1:0] xlog[$];

    task automatic push_stream(input logic [N*W-1:0] m, input logic [N-1:0] mp);
        word_t w;
        w.data = W'(N - $countones(mp));
        w.hdr = 1'b1; w.row = 0; w.col = 0; w.last = 1'b0;
        expq.push_back(w);
        for (int k = 0; k < N; k++) begin
            w.data = m[k*W +: W];
            w.hdr  = 1'b0;
            w.row  = k / C;
            w.col  = k % C;
            w.last = (k == N - 1);
            expq.push_back(w);
        end
    endtask

    // Inputs change only at posedge+1, so values seen here are what the
    // next posedge will sample.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_valid", 64'(out_valid), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_ovr", 64'(overrun_err), 64'd0);
            chk("rst_data", 64'(out_data), 64'd0);
            chk("rst_flags", {61'd0, out_hdr, out_last, out_row | out_col}, 64'd0);
            expq.delete();
            m_ovr    = 1'b0;
            prev_rdy = 1'b1;
        end else begin
            logic full;
            full = (expq.size() > 0);
            chk("valid", 64'(out_valid), 64'(full));
            chk("busy", 64'(busy), 64'(full));
            chk("overrun", 64'(overrun_err), 64'(m_ovr));
            if (full) begin
                chk("data", 64'(out_data), 64'(expq[0].data));
                chk("hdr", 64'(out_hdr), 64'(expq[0].hdr));
                chk("row", 64'(out_row), 64'(expq[0].row));
                chk("col", 64'(out_col), 64'(expq[0].col));
                chk("last", 64'(out_last), 64'(expq[0].last));
            end
            if (out_valid && ready) xlog.push_back(out_data);
            if (rdy && !prev_rdy) begin
                if (full) m_ovr = 1'b1;
            end
            if (full && ready) void'(expq.pop_front());
            if (rdy && !prev_rdy && !full) push_stream(mat, map);
            prev_rdy = rdy;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while ((busy || expq.size() > 0) && i < 200) begin
            step(1);
            i++;
        end
        n_cmp++;
        if (busy || expq.size() > 0) begin
            n_bad++;
            $display("FAIL idle_timeout: busy %0b pending %0d expected idle", busy, expq.size());
        end
    endtask

    task automatic chk_log5(input string name);
        chk({name, "_count"}, 64'(xlog.size()), 64'd5);
        for (int k = 0; k < 5 && k < xlog.size(); k++)
            chk({name, "_word"}, 64'(xlog[k]), 64'(k));
    endtask

    typedef struct {
        logic [N-1:0]   map;
        logic [N*W-1:0] mat;
        logic [5*W-1:0] stream;   // word k at [k*W +: W], header first
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{4'b1111, {32'd4, 32'd3, 32'd2, 32'd1},
                    {32'd4, 32'd3, 32'd2, 32'd1, 32'd0}};
        vecs[1] = '{4'b0110, {32'd40, 32'd30, 32'd20, 32'd10},
                    {32'd40, 32'd30, 32'd20, 32'd10, 32'd2}};
        vecs[2] = '{4'b0000, {32'h8000_0000, 32'h0001_8000, 32'h7FFF_FFFF, 32'hFFFF_0000},
                    {32'h8000_0000, 32'h0001_8000, 32'h7FFF_FFFF, 32'hFFFF_0000, 32'd4}};
        vecs[3] = '{4'b1000, {32'd9, 32'd0, 32'hDEAD_BEEF, 32'd7},
                    {32'd9, 32'd0, 32'hDEAD_BEEF, 32'd7, 32'd3}};

        rdy = 1'b0; ready = 1'b1; mat = '0; map = '1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step(2);

        // Table-driven full streams with ready held high.
        foreach (vecs[v]) begin
            mat = vecs[v].mat; map = vecs[v].map; ready = 1'b1;
            rdy = 1'b1;
            step(1);
            rdy = 1'b0;
            for (int k = 0; k < 5; k++) begin
                chk("tbl_valid", 64'(out_valid), 64'd1);
                chk("tbl_data", 64'(out_data), 64'(vecs[v].stream[k*W +: W]));
                chk("tbl_last", 64'(out_last), 64'(k == 4));
                step(1);
            end
            chk("tbl_done", 64'(out_valid), 64'd0);
            step(1);
        end

        // Backpressure 1,0,0,1: each word held, no duplicates.
        mat = {32'd4, 32'd3, 32'd2, 32'd1}; map = 4'b1111;
        rdy = 1'b1; ready = 1'b0;
        step(1);
        rdy = 1'b0;
        xlog.delete();
        for (int i = 0; i < 40 && busy; i++) begin
            ready = (i % 4 == 0) || (i % 4 == 3);
            step(1);
        end
        ready = 1'b1;
        wait_idle();
        chk_log5("bp");

        // Overrun during drain: original data still streamed.
        xlog.delete();
        rdy = 1'b1;
        step(1);
        rdy = 1'b0;
        step(2);
        mat = {32'd8, 32'd7, 32'd6, 32'd5};
        rdy = 1'b1;
        step(1);
        rdy = 1'b0;
        wait_idle();
        chk_log5("ovr");
        chk("ovr_set", 64'(overrun_err), 64'd1);
        step(3);
        chk("ovr_sticky", 64'(overrun_err), 64'd1);

        // Async reset after the second data word; held rdy must not restart.
        mat = {32'd4, 32'd3, 32'd2, 32'd1};
        rdy = 1'b1;
        step(1);
        rdy = 1'b0;
        step(2);
        chk("pre_rst_data", 64'(out_data), 64'd2);
        rdy = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("async_valid", 64'(out_valid), 64'd0);
        chk("async_busy", 64'(busy), 64'd0);
        step(1);
        rst = 1'b0;
        step(4);
        chk("held_rdy_busy", 64'(busy), 64'd0);
        chk("post_rst_ovr", 64'(overrun_err), 64'd0);
        rdy = 1'b0;
        step(1);
        rdy = 1'b1;
        step(1);
        chk("restart_hdr", 64'(out_hdr), 64'd1);
        chk("restart_valid", 64'(out_valid), 64'd1);
        rdy = 1'b0;
        wait_idle();

        // Capture coincident with the final transfer.
        rdy = 1'b1;
        step(1);
        rdy = 1'b0;
        step(4);
        chk("fin_last", 64'(out_last), 64'd1);
        rdy = 1'b1;
        step(1);
        chk("fin_busy", 64'(busy), 64'd0);
        chk("fin_ovr", 64'(overrun_err), 64'd1);
        step(3);
        chk("fin_no_stream", 64'(out_valid), 64'd0);
        rdy = 1'b0;
        step(1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 5) == 0) rdy = ~rdy;
            mat = {$urandom, $urandom, $urandom, $urandom};
            map = 4'($urandom);
            step(1);
        end
        rdy = 1'b0; ready = 1'b1;
        wait_idle();
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
